instruction_fetch_ctrl: RTL and testbench
=========================================

# instruction_fetch_ctrl

Fetch sequencer that owns the program counter and drives the combinational-read `InstructionMemory`. It presents one instruction per cycle to decode over a valid/ready handshake, and accepts PC redirects from branch/jump resolution. It stops fetching when it fetches a programmable halt word. It sits between `InstructionMemory` and the decode stage.

## Interface
- `ADDRESS_WIDTH`, 32, PC and memory address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `HALT_INSTR`, 32'hFFFF_FFFF, instruction word that stops fetch
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  leave IDLE and begin fetching
- `imem_address`  out  ADDRESS_WIDTH  drives `InstructionMemory.address`; equals the PC register
- `imem_instruction`  in  DATA_WIDTH  from `InstructionMemory.instruction`, valid in the same cycle
- `redirect_valid`  in  1  load a new PC, single-cycle pulse
- `redirect_pc`  in  ADDRESS_WIDTH  redirect target; bits [1:0] are forced to 0
- `out_valid`  out  1  output instruction valid
- `out_ready`  in  1  decode accepts the output
- `out_instr`  out  DATA_WIDTH  fetched word
- `out_pc`  out  ADDRESS_WIDTH  address of `out_instr`
- `halted`  out  1  high while in HALT

## Operation
- The FSM has three states: IDLE, RUN, HALT.
- **Reset values:** state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
- **Fetch enable:** fetch_en = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- **On fetch_en:** out_instr<=imem_instruction, out_pc<=pc, out_valid<=1.
  - If imem_instruction==HALT_INSTR: the word is still delivered, pc holds, and the state becomes HALT.
  - Otherwise pc<=pc+4, modulo 2^ADDRESS_WIDTH. 32'hFFFF_FFFC wraps to 0.
- **Stall:** while out_valid && !out_ready, out_valid, out_instr, out_pc and pc all hold.
- **Drain:** when out_valid && out_ready and fetch_en is low, out_valid<=0.
- **IDLE:** no fetch. start moves the state to RUN.
- **HALT:** no fetch. The pending output still drains normally. Only a redirect or reset leaves HALT.
- **Redirect (any state):**
  - pc<={redirect_pc[ADDRESS_WIDTH-1:2],2'b00}.
  - out_valid<=0; the pending output is discarded even if out_ready is high that cycle.
  - RUN and HALT go to RUN. IDLE stays IDLE unless start is also high, in which case it goes to RUN.
- **Priority:** reset > redirect > halt detection > normal fetch. start is ignored outside IDLE.

## Timing
- Combinational path: imem_address = pc. The memory read completes within the cycle and is captured at the next edge.
- start sampled at edge E0 → state RUN after E0 → first capture at E1 → out_valid high after E1.
- redirect sampled at E0 → new pc after E0 → capture at E1. This gives exactly one bubble cycle.
- Steady state with out_ready held high: one instruction per cycle, and out_pc increments by 4 every cycle.
- HALT_INSTR captured at edge En: halted=1 and out_valid=1 after En. No capture occurs at En+1.
- Asynchronous reset assertion mid-operation immediately forces all outputs to their reset values. Deassertion is used synchronously; the first active edge after it sees IDLE.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two outputs:
  - `perf_fetch_count[31:0]`: increments on every fetch_en cycle.
  - `perf_stall_count[31:0]`: increments on every RUN cycle with out_valid && !out_ready.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by redirect.
- Undefined: the ports and counter logic are absent. Fetch behaviour is identical in both cases.

## Structure
- Package `cpu_fetch_pkg` holds:
  - `fetch_state_e` {FETCH_IDLE, FETCH_RUN, FETCH_HALT}
  - `PC_STEP`=4
  - `DEFAULT_HALT_INSTR`
- One optional sub-module, `fetch_perf_counters`, instantiated only under `FETCH_PERF_CNT_EN`.
- The bench instantiates `instruction_fetch_ctrl` with `InstructionMemory`, preloaded via $readmemh.

## Test plan
- **Reset and start:** memory words 0..3 = 11,22,33,44; hold rst_n low, then release; pulse start with out_ready=1 → out_valid high the cycle after RUN, with out_pc=0,4,8,12 and out_instr=11,22,33,44 on consecutive cycles; halted=0.
- **Backpressure:** drop out_ready for 3 cycles while out_pc=4 is presented → out_pc=4 and out_instr=22 are held stable for 3 cycles, and the next value is out_pc=8 with no word skipped or duplicated.
- **Redirect:** pulse redirect_valid with redirect_pc=32'h0000_0013 while out_valid=1 → one cycle with out_valid=0, then out_pc=32'h10; the previously pending word is never accepted.
- **Halt:** word at 0x8 = 32'hFFFF_FFFF → it is delivered with out_pc=8, halted=1, and out_valid falls once it is accepted. Then redirect to 0 → halted=0 and fetching resumes at pc 0.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-stall:** assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid=0, out_pc=0 and out_instr=0 immediately; the state is IDLE and start is required to resume. With `FETCH_PERF_CNT_EN` defined, both counters read 0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

  localparam int unsigned PC_STEP            = 4;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch and stall event counters for the fetch sequencer.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        stall,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_stall_count
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_en && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// PC owner and fetch sequencer feeding decode over valid/ready.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall performance counters.
module instruction_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]      HALT_INSTR    = DATA_WIDTH'(DEFAULT_HALT_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0]    imem_instruction,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_count,
  output logic [31:0]              perf_stall_count
`endif
);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_instr_q, out_instr_d;
  logic [ADDRESS_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                     fetch_en;

  assign fetch_en = (state_q == FETCH_RUN) && (!out_valid_q || out_ready) && !redirect_valid;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      // Redirect wins over everything but reset and discards the pending word.
      pc_d        = redirect_pc & ~ADDRESS_WIDTH'(3);
      out_valid_d = 1'b0;
      if ((state_q != FETCH_IDLE) || start) state_d = FETCH_RUN;
    end else begin
      if ((state_q == FETCH_IDLE) && start) state_d = FETCH_RUN;
      if (fetch_en) begin
        out_instr_d = imem_instruction;
        out_pc_d    = pc_q;
        out_valid_d = 1'b1;
        if (imem_instruction == HALT_INSTR) state_d = FETCH_HALT;
        else                                pc_d    = pc_q + ADDRESS_WIDTH'(PC_STEP);
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_address = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign halted       = (state_q == FETCH_HALT);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_en         (fetch_en),
    .stall            ((state_q == FETCH_RUN) && out_valid_q && !out_ready),
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench: two fetch controllers (reset PC 0 and near-wrap) against a rule-level model.
module tb_instruction_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [1:0]  M_IDLE = 2'd0, M_RUN = 2'd1, M_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n, start, rv, rdy;
  logic [31:0] rpc;
  logic [31:0] mem [256];

  logic [31:0] d0_addr, d0_instr, d0_opc, d1_addr, d1_instr, d1_opc;
  logic        d0_valid, d0_halted, d1_valid, d1_halted;
  logic [31:0] d0_pf, d0_ps, d1_pf, d1_ps;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_address(d0_addr),
    .imem_instruction(mem[d0_addr[9:2]]), .redirect_valid(rv), .redirect_pc(rpc),
    .out_valid(d0_valid), .out_ready(rdy), .out_instr(d0_instr), .out_pc(d0_opc),
    .halted(d0_halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(d0_pf), .perf_stall_count(d0_ps)
`endif
  );

  instruction_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_address(d1_addr),
    .imem_instruction(mem[d1_addr[9:2]]), .redirect_valid(rv), .redirect_pc(rpc),
    .out_valid(d1_valid), .out_ready(rdy), .out_instr(d1_instr), .out_pc(d1_opc),
    .halted(d1_halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(d1_pf), .perf_stall_count(d1_ps)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign d0_pf = '0; assign d0_ps = '0; assign d1_pf = '0; assign d1_ps = '0;
`endif

  // Reference model: what the fetch unit must present, derived from the behavioural rules.
  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] opc;
    logic [31:0] nf;
    logic [31:0] ns;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset(input logic [31:0] rst_pc);
    mdl_t s;
    s.mode = M_IDLE; s.pc = rst_pc; s.v = 1'b0; s.instr = '0; s.opc = '0; s.nf = '0; s.ns = '0;
    return s;
  endfunction

  function automatic mdl_t mstep(input mdl_t s);
    mdl_t        n = s;
    logic [31:0] w = mem[s.pc[9:2]];
    bit          fe = (s.mode == M_RUN) && (!s.v || rdy) && !rv;
    if (fe && s.nf != 32'hFFFF_FFFF) n.nf = s.nf + 1;
    if (s.mode == M_RUN && s.v && !rdy && s.ns != 32'hFFFF_FFFF) n.ns = s.ns + 1;
    if (rv) begin
      n.pc = {rpc[31:2], 2'b00};
      n.v  = 1'b0;
      n.mode = (s.mode == M_IDLE && !start) ? M_IDLE : M_RUN;
    end else begin
      if (s.mode == M_IDLE && start) n.mode = M_RUN;
      if (fe) begin
        n.instr = w; n.opc = s.pc; n.v = 1'b1;
        if (w == HALT) n.mode = M_HALT;
        else           n.pc = s.pc + 32'd4;
      end else if (s.v && rdy) begin
        n.v = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset(32'h0000_0000);
      m1 <= mreset(32'hFFFF_FFF8);
    end else begin
      m0 <= mstep(m0);
      m1 <= mstep(m1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk1("d0_valid", d0_valid, m0.v);
      chk("d0_pc", d0_opc, m0.opc);
      chk("d0_instr", d0_instr, m0.instr);
      chk1("d0_halted", d0_halted, m0.mode == M_HALT);
      chk("d0_addr", d0_addr, m0.pc);
      chk1("d1_valid", d1_valid, m1.v);
      chk("d1_pc", d1_opc, m1.opc);
      chk("d1_instr", d1_instr, m1.instr);
      chk1("d1_halted", d1_halted, m1.mode == M_HALT);
      chk("d1_addr", d1_addr, m1.pc);
`ifdef FETCH_PERF_CNT_EN
      chk("d0_perf_fetch", d0_pf, m0.nf);
      chk("d0_perf_stall", d0_ps, m0.ns);
      chk("d1_perf_fetch", d1_pf, m1.nf);
      chk("d1_perf_stall", d1_ps, m1.ns);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] pc, input logic [31:0] ins);
    chk1({nm, "_valid"}, d0_valid, 1'b1);
    chk({nm, "_pc"}, d0_opc, pc);
    chk({nm, "_instr"}, d0_instr, ins);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rv = 1'b0; rpc = '0; rdy = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'h55;
    mem[8'hFE] = 32'hAAAA_0001; mem[8'hFF] = 32'hAAAA_0002;

    repeat (3) tick();
    cmp_en = 1'b1;
    chk1("rst_valid", d0_valid, 1'b0);
    chk("rst_pc", d0_opc, 32'h0);
    chk("rst_instr", d0_instr, 32'h0);
    chk1("rst_halted", d0_halted, 1'b0);
    chk("rst_addr0", d0_addr, 32'h0);
    chk("rst_addr1", d1_addr, 32'hFFFF_FFF8);

    rst_n = 1'b1;
    tick();
    chk1("idle_no_fetch", d0_valid, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk1("run_no_out_yet", d0_valid, 1'b0);
    tick(); expect_out("first", 32'h0, 32'h11);
    chk1("first_halted", d0_halted, 1'b0);
    chk("wrap0", d1_opc, 32'hFFFF_FFF8);
    tick(); expect_out("second", 32'h4, 32'h22);
    chk("wrap1", d1_opc, 32'hFFFF_FFFC);

    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); expect_out("stall", 32'h4, 32'h22); end
    rdy = 1'b1;
    tick(); expect_out("after_stall", 32'h8, 32'h33);
    chk("wrap2", d1_opc, 32'h0);
    tick(); expect_out("fourth", 32'hC, 32'h44);

    rv = 1'b1; rpc = 32'h0000_0013; tick(); rv = 1'b0;
    chk1("redir_bubble", d0_valid, 1'b0);
    tick(); expect_out("redir_target", 32'h10, 32'h55);

    mem[2] = HALT;
    rv = 1'b1; rpc = 32'h0; tick(); rv = 1'b0;
    chk1("halt_pre_bubble", d0_valid, 1'b0);
    tick(); expect_out("halt_w0", 32'h0, 32'h11);
    tick(); expect_out("halt_w1", 32'h4, 32'h22);
    tick(); expect_out("halt_word", 32'h8, HALT);
    chk1("halt_flag", d0_halted, 1'b1);
    tick();
    chk1("halt_drained", d0_valid, 1'b0);
    chk1("halt_stays", d0_halted, 1'b1);
    chk("halt_pc_hold", d0_addr, 32'h8);
    tick();
    chk1("halt_no_fetch", d0_valid, 1'b0);
    rv = 1'b1; rpc = 32'h0; tick(); rv = 1'b0;
    chk1("unhalt", d0_halted, 1'b0);
    tick(); expect_out("resume", 32'h0, 32'h11);

    rdy = 1'b0; tick(); tick();
    #2 rst_n = 1'b0; #1;
    chk1("async_valid", d0_valid, 1'b0);
    chk("async_pc", d0_opc, 32'h0);
    chk("async_instr", d0_instr, 32'h0);
    chk1("async_halted", d0_halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_perf_f", d0_pf, 32'h0);
    chk("async_perf_s", d0_ps, 32'h0);
`endif
    tick(); rst_n = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk1("post_rst_idle", d0_valid, 1'b0); end
    start = 1'b1; tick(); start = 1'b0;
    tick(); expect_out("restart", 32'h0, 32'h11);

    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      start = ($urandom_range(0, 3) == 0);
      rv    = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      rdy   = ($urandom_range(0, 3) != 0);
    end
    tick();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
